// File: rtl/dma_hold_arbiter_if.sv
// Shared CPU / DMA / memory bus bundle for the DMA hold arbiter.
// The arbiter takes the slave side; the surrounding system takes the master side.
interface dma_hold_arbiter_if;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wd;
   logic [31:0] cpu_rd;
   logic        cpu_stall;

   logic        HOLD;
   logic        HOLD_ACK;

   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wd;
   logic [31:0] dma_rd;

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  cpu_we, cpu_addr, cpu_wd, HOLD, dma_we, dma_addr, dma_wd, mem_rd,
      output cpu_rd, cpu_stall, HOLD_ACK, dma_rd, mem_we, mem_addr, mem_wd
   );

   modport master (
      output cpu_we, cpu_addr, cpu_wd, HOLD, dma_we, dma_addr, dma_wd, mem_rd,
      input  cpu_rd, cpu_stall, HOLD_ACK, dma_rd, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/dma_hold_arbiter.sv
// Hands the single memory port between the CPU and a coprocessor DMA using a
// HOLD/HOLD_ACK handshake, with drain, release and minimum-gap phases.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | CPU owns memory, waiting for HOLD
// DRAIN   | CPU stalled, memory writes blocked, counting down to grant
// GRANT   | DMA owns memory, HOLD_ACK high
// RELEASE | one dead cycle after HOLD drops, CPU still stalled
// GAP     | CPU owns memory again; HOLD ignored until back in IDLE
module dma_hold_arbiter #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned MIN_GAP      = 2,
   parameter int unsigned MAX_HOLD     = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   dma_hold_arbiter_if.slave        bus,
   input  logic                     err_clr,
   output logic                     hold_err,
   output logic [15:0]              grant_count
);

   localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int unsigned GAP_W   = (MIN_GAP < 2)      ? 1 : $clog2(MIN_GAP + 1);
   localparam int unsigned GRANT_W = (MAX_HOLD < 2)     ? 1 : $clog2(MAX_HOLD + 1);

   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(MIN_GAP);
   localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
   localparam logic [GRANT_W-1:0] GRANT_MAX  = GRANT_W'(MAX_HOLD);
   localparam logic [GRANT_W-1:0] GRANT_ONE  = GRANT_W'(1);
   localparam logic               SKIP_DRAIN = (DRAIN_CYCLES == 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_GRANT,
      ST_RELEASE,
      ST_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [GRANT_W-1:0]   grant_cyc_q, grant_cyc_d;
   logic [15:0]          grant_count_q, grant_count_d;
   logic                 hold_err_q, hold_err_d;
   logic                 hold_ack_q, hold_ack_d;
   logic                 cpu_stall_q, cpu_stall_d;
   logic                 enter_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         drain_cnt_q   <= '0;
         gap_cnt_q     <= '0;
         grant_cyc_q   <= '0;
         grant_count_q <= '0;
         hold_err_q    <= 1'b0;
         hold_ack_q    <= 1'b0;
         cpu_stall_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         grant_cyc_q   <= grant_cyc_d;
         grant_count_q <= grant_count_d;
         hold_err_q    <= hold_err_d;
         hold_ack_q    <= hold_ack_d;
         cpu_stall_q   <= cpu_stall_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      grant_cyc_d   = grant_cyc_q;
      grant_count_d = grant_count_q;
      hold_err_d    = hold_err_q;
      enter_grant   = 1'b0;

      // clear first so a same-cycle timeout below overrides it
      if (err_clr) begin
         hold_err_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.HOLD) begin
               if (SKIP_DRAIN) begin
                  enter_grant = 1'b1;
               end else begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.HOLD) begin
               state_d     = ST_GAP;
               drain_cnt_d = '0;
               gap_cnt_d   = GAP_LOAD;
            end else if (drain_cnt_q <= DRAIN_ONE) begin
               drain_cnt_d = '0;
               enter_grant = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q - DRAIN_ONE;
            end
         end
         ST_GRANT: begin
            if (grant_cyc_q != GRANT_MAX) begin
               grant_cyc_d = grant_cyc_q + GRANT_ONE;
               if (grant_cyc_d == GRANT_MAX) begin
                  hold_err_d = 1'b1;
               end
            end
            if (!bus.HOLD) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
         end
         ST_GAP: begin
            if (gap_cnt_q <= GAP_ONE) begin
               state_d   = ST_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (enter_grant) begin
         state_d     = ST_GRANT;
         grant_cyc_d = '0;
         if (grant_count_q != 16'hFFFF) begin
            grant_count_d = grant_count_q + 16'd1;
         end
      end

      hold_ack_d  = (state_d == ST_GRANT);
      cpu_stall_d = (state_d == ST_DRAIN) || (state_d == ST_GRANT) || (state_d == ST_RELEASE);
   end

   // Memory mux keys off the registered state only, so HOLD never reaches mem_*.
   always_comb begin
      bus.mem_we   = 1'b0;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_wd   = bus.cpu_wd;
      case (state_q)
         ST_IDLE, ST_GAP: begin
            bus.mem_we = bus.cpu_we;
         end
         ST_GRANT: begin
            bus.mem_we   = bus.dma_we;
            bus.mem_addr = bus.dma_addr;
            bus.mem_wd   = bus.dma_wd;
         end
         default: begin
            bus.mem_we = 1'b0;
         end
      endcase
   end

   assign bus.cpu_rd    = bus.mem_rd;
   assign bus.dma_rd    = bus.mem_rd;
   assign bus.HOLD_ACK  = hold_ack_q;
   assign bus.cpu_stall = cpu_stall_q;
   assign hold_err      = hold_err_q;
   assign grant_count   = grant_count_q;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Directed bench for dma_hold_arbiter: a main instance (MAX_HOLD=16) and a
// shrunk instance used to drive the grant counter into saturation.
module tb_dma_hold_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        err_clr,  hold_err;
   logic [15:0] grant_count;
   logic        err_clr2, hold_err2;
   logic [15:0] grant_count2;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   dma_hold_arbiter_if bus  ();
   dma_hold_arbiter_if bus2 ();

   dma_hold_arbiter #(.DRAIN_CYCLES(2), .MIN_GAP(2), .MAX_HOLD(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .err_clr     (err_clr),
      .hold_err    (hold_err),
      .grant_count (grant_count)
   );

   dma_hold_arbiter #(.DRAIN_CYCLES(0), .MIN_GAP(0), .MAX_HOLD(4)) dut_sat (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus2),
      .err_clr     (err_clr2),
      .hold_err    (hold_err2),
      .grant_count (grant_count2)
   );

   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;
   end
   assign bus.mem_rd  = mem[bus.mem_addr[9:2]];
   assign bus2.mem_rd = 32'h0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      #4ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      err_clr = 1'b0;  err_clr2 = 1'b0;
      bus.cpu_we = 1'b0;  bus.cpu_addr = 32'h0;  bus.cpu_wd = 32'h0;
      bus.HOLD = 1'b0;    bus.dma_we = 1'b0;     bus.dma_addr = 32'h0; bus.dma_wd = 32'h0;
      bus2.cpu_we = 1'b0; bus2.cpu_addr = 32'h0; bus2.cpu_wd = 32'h0;
      bus2.HOLD = 1'b0;   bus2.dma_we = 1'b0;    bus2.dma_addr = 32'h0; bus2.dma_wd = 32'h0;
      tick_n(2);

      check_eq("rst_ack",   32'(bus.HOLD_ACK),  32'd0);
      check_eq("rst_stall", 32'(bus.cpu_stall), 32'd0);
      check_eq("rst_gcnt",  32'(grant_count),   32'd0);
      check_eq("rst_herr",  32'(hold_err),      32'd0);
      rst = 1'b0;
      tick();

      // CPU owns memory in IDLE
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'h1111_2222;
      #1;
      check_eq("idle_mem_we",   32'(bus.mem_we), 32'd1);
      check_eq("idle_mem_addr", bus.mem_addr,    32'h40);
      tick();
      bus.cpu_we = 1'b0;
      check_eq("idle_write", mem[8'h10],  32'h1111_2222);
      check_eq("cpu_rd",     bus.cpu_rd,  32'h1111_2222);

      bus.dma_we = 1'b1; bus.dma_addr = 32'h80; bus.dma_wd = 32'h0BAD_0BAD;
      tick();
      check_eq("dma_idle_nowrite", mem[8'h20], 32'h0);

      // basic grant: HOLD sampled in cycle c, stall from c+1, ack at c+3
      bus.dma_addr = 32'h100; bus.dma_wd = 32'hDEAD_BEEF;
      bus.HOLD = 1'b1;
      tick();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h44; bus.cpu_wd = 32'h5555_5555;
      #1;
      check_eq("drain_stall",    32'(bus.cpu_stall), 32'd1);
      check_eq("drain_ack0",     32'(bus.HOLD_ACK),  32'd0);
      check_eq("drain_mem_we",   32'(bus.mem_we),    32'd0);
      check_eq("drain_mem_addr", bus.mem_addr,       32'h44);
      tick();
      check_eq("drain2_ack0", 32'(bus.HOLD_ACK), 32'd0);
      tick();
      bus.cpu_we = 1'b0;
      check_eq("grant_ack",      32'(bus.HOLD_ACK),  32'd1);
      check_eq("grant_stall",    32'(bus.cpu_stall), 32'd1);
      check_eq("grant_gcnt1",    32'(grant_count),   32'd1);
      check_eq("grant_mem_addr", bus.mem_addr,       32'h100);

      // drop HOLD, re-raise one cycle later
      bus.HOLD = 1'b0;
      tick();
      check_eq("dma_write",      mem[8'h40],         32'hDEAD_BEEF);
      check_eq("drain_blocked",  mem[8'h11],         32'h0);
      check_eq("release_ack",    32'(bus.HOLD_ACK),  32'd0);
      check_eq("release_stall",  32'(bus.cpu_stall), 32'd1);
      check_eq("release_mem_we", 32'(bus.mem_we),    32'd0);
      bus.HOLD = 1'b1;
      bus.dma_wd = 32'h1234_5678;
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h200; bus.cpu_wd = 32'hCAFE_0001;
      tick();
      check_eq("gap1_stall",    32'(bus.cpu_stall), 32'd0);
      check_eq("gap1_mem_we",   32'(bus.mem_we),    32'd1);
      check_eq("gap1_mem_addr", bus.mem_addr,       32'h200);
      tick();
      bus.cpu_we = 1'b0;
      check_eq("gap2_stall", 32'(bus.cpu_stall), 32'd0);
      tick();
      check_eq("b2b_idle_stall", 32'(bus.cpu_stall), 32'd0);
      check_eq("gap_cpu_write",  mem[8'h80],         32'hCAFE_0001);
      tick();
      check_eq("b2b_drain_stall", 32'(bus.cpu_stall), 32'd1);
      tick_n(2);
      check_eq("b2b_ack",   32'(bus.HOLD_ACK), 32'd1);
      check_eq("b2b_gcnt2", 32'(grant_count),  32'd2);
      check_eq("dma_rd",    bus.dma_rd,        32'hDEAD_BEEF);

      // timeout: grant cycle k has counted k cycles; flag appears at k=16
      check_eq("herr_cyc0", 32'(hold_err), 32'd0);
      tick();
      check_eq("dma_rd_new", bus.dma_rd, 32'h1234_5678);
      tick_n(14);
      check_eq("herr_cyc15", 32'(hold_err), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("herr_set_wins", 32'(hold_err),     32'd1);
      check_eq("ack_cyc16",     32'(bus.HOLD_ACK), 32'd1);
      tick_n(4);
      check_eq("ack_cyc20",  32'(bus.HOLD_ACK), 32'd1);
      check_eq("herr_cyc20", 32'(hold_err),     32'd1);
      bus.HOLD = 1'b0;
      tick();
      check_eq("herr_sticky", 32'(hold_err),     32'd1);
      check_eq("rel2_ack",    32'(bus.HOLD_ACK), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("herr_clr", 32'(hold_err), 32'd0);
      tick_n(2);

      // grant-cycle counter must saturate, not wrap and re-trip the flag
      bus.dma_we = 1'b0;
      bus.HOLD = 1'b1;
      tick_n(3);
      check_eq("g3_gcnt", 32'(grant_count), 32'd3);
      tick_n(16);
      check_eq("g3_herr_set", 32'(hold_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("g3_herr_clr", 32'(hold_err), 32'd0);
      tick_n(34);
      check_eq("no_wrap_herr", 32'(hold_err),     32'd0);
      check_eq("no_wrap_ack",  32'(bus.HOLD_ACK), 32'd1);
      bus.HOLD = 1'b0;
      tick_n(4);

      // abort in DRAIN, then HOLD during GAP is ignored
      bus.HOLD = 1'b1;
      tick();
      check_eq("abort_drain_stall", 32'(bus.cpu_stall), 32'd1);
      bus.HOLD = 1'b0;
      tick();
      check_eq("abort_gap_stall", 32'(bus.cpu_stall), 32'd0);
      check_eq("abort_ack",       32'(bus.HOLD_ACK),  32'd0);
      bus.HOLD = 1'b1;
      tick();
      check_eq("abort_gap2_stall", 32'(bus.cpu_stall), 32'd0);
      tick();
      check_eq("gap_ignores_hold", 32'(bus.cpu_stall), 32'd0);
      tick();
      check_eq("idle_takes_hold", 32'(bus.cpu_stall), 32'd1);
      bus.HOLD = 1'b0;
      tick();
      check_eq("abort_gcnt", 32'(grant_count), 32'd3);
      tick_n(2);

      // reset in the middle of a grant
      bus.HOLD = 1'b1;
      tick_n(3);
      check_eq("g4_gcnt", 32'(grant_count), 32'd4);
      tick_n(3);
      bus.cpu_addr = 32'h300;
      rst = 1'b1;
      #1;
      check_eq("rst_mid_ack",   32'(bus.HOLD_ACK),  32'd0);
      check_eq("rst_mid_stall", 32'(bus.cpu_stall), 32'd0);
      check_eq("rst_mid_addr",  bus.mem_addr,       32'h300);
      check_eq("rst_mid_gcnt",  32'(grant_count),   32'd0);
      #1;
      rst = 1'b0;
      tick();
      check_eq("post_rst_drain", 32'(bus.cpu_stall), 32'd1);
      check_eq("post_rst_ack0",  32'(bus.HOLD_ACK),  32'd0);
      tick_n(2);
      check_eq("post_rst_ack",  32'(bus.HOLD_ACK), 32'd1);
      check_eq("post_rst_gcnt", 32'(grant_count),  32'd1);
      bus.HOLD = 1'b0;
      tick_n(4);

      // saturation: DRAIN_CYCLES=0, MIN_GAP=0 gives one grant per 4 cycles
      for (int i = 0; i < 65537; i++) begin
         bus2.HOLD = 1'b1;
         tick();
         if (i == 0) check_eq("sat_ack_first", 32'(bus2.HOLD_ACK), 32'd1);
         bus2.HOLD = 1'b0;
         tick_n(3);
         if (i == 2)     check_eq("sat_gcnt3",    32'(grant_count2), 32'd3);
         if (i == 65533) check_eq("sat_gcnt_fffe", 32'(grant_count2), 32'h0000_FFFE);
      end
      check_eq("sat_gcnt_ffff", 32'(grant_count2), 32'h0000_FFFF);
      check_eq("sat_herr",      32'(hold_err2),    32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
